// File: rtl/wwm_turn_if.sv
// World War Math turn controller bus: player, flight and HUD signals.
// master drives the controller inputs, slave is the controller itself.
interface wwm_turn_if #(
  parameter int SCORE_W = 4,
  parameter int TIMER_W = 10
);
  logic               Start;
  logic               Ack;
  logic               p1_fire;
  logic               p2_fire;
  logic               frame_tick;
  logic               flight_hit;
  logic               flight_miss;
  logic               launch;
  logic               active_player;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [TIMER_W-1:0] aim_time;
  logic [1:0]         winner;
  logic               q_Idle;
  logic               q_Aim;
  logic               q_Flight;
  logic               q_GameOver;

  modport master (
    output Start, Ack, p1_fire, p2_fire,
    output frame_tick, flight_hit, flight_miss,
    input  launch, active_player,
    input  p1_score, p2_score, aim_time, winner,
    input  q_Idle, q_Aim, q_Flight, q_GameOver
  );

  modport slave (
    input  Start, Ack, p1_fire, p2_fire,
    input  frame_tick, flight_hit, flight_miss,
    output launch, active_player,
    output p1_score, p2_score, aim_time, winner,
    output q_Idle, q_Aim, q_Flight, q_GameOver
  );
endinterface

// File: rtl/wwm_turn_ctrl.sv
// Two-player turn scheduler: grants the projectile engine, keeps scores,
// runs the aim timer and flight watchdog, and declares the winner.
module wwm_turn_ctrl #(
  parameter int WIN_SCORE     = 3,
  parameter int SCORE_W       = 4,
  parameter int AIM_FRAMES    = 600,
  parameter int FLIGHT_FRAMES = 255,
  parameter int TIMER_W       = 10
) (
  input  logic       clk,
  input  logic       Reset,
  wwm_turn_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_AIM    = 4'b0010,
    S_FLIGHT = 4'b0100,
    S_OVER   = 4'b1000
  } state_e;

  localparam logic [TIMER_W-1:0] AIM_LD = TIMER_W'(AIM_FRAMES);
  localparam logic [TIMER_W-1:0] WD_END = TIMER_W'(FLIGHT_FRAMES - 1);
  localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);
  localparam logic [SCORE_W-1:0] S_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] S_MAX  = '1;
  localparam logic [SCORE_W-1:0] S_WIN  = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic               launch_q, launch_d;
  logic               act_q, act_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic [TIMER_W-1:0] aim_q, aim_d;
  logic [TIMER_W-1:0] wd_q, wd_d;
  logic [1:0]         win_q, win_d;

  logic               fire_ok;
  logic               wd_exp;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] new_score;

  assign fire_ok   = act_q ? bus.p2_fire : bus.p1_fire;
  assign wd_exp    = bus.frame_tick && (wd_q == WD_END);
  assign cur_score = act_q ? p2_q : p1_q;
  assign new_score = (cur_score == S_MAX) ? cur_score
                                          : cur_score + S_ONE;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      act_q    <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      aim_q    <= '0;
      wd_q     <= '0;
      win_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      act_q    <= act_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      aim_q    <= aim_d;
      wd_q     <= wd_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    act_d    = act_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    aim_d    = aim_q;
    wd_d     = wd_q;
    win_d    = win_q;
    unique case (1'b1)
      state_q[0]: begin
        if (bus.Start) begin
          state_d = S_AIM;
          act_d   = 1'b0;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 2'b00;
          aim_d   = AIM_LD;
        end
      end
      state_q[1]: begin
        // fire beats an expiring tick in the same cycle
        if (fire_ok) begin
          state_d  = S_FLIGHT;
          launch_d = 1'b1;
          wd_d     = '0;
        end else if (bus.frame_tick) begin
          if (aim_q == T_ONE) begin
            act_d = ~act_q;
            aim_d = AIM_LD;
          end else if (aim_q != '0) begin
            aim_d = aim_q - T_ONE;
          end
        end
      end
      state_q[2]: begin
        if (bus.flight_hit) begin
          if (act_q) p2_d = new_score;
          else       p1_d = new_score;
          if (new_score == S_WIN) begin
            state_d = S_OVER;
            win_d   = act_q ? 2'b10 : 2'b01;
          end else begin
            state_d = S_AIM;
            act_d   = ~act_q;
            aim_d   = AIM_LD;
          end
        end else if (bus.flight_miss || wd_exp) begin
          state_d = S_AIM;
          act_d   = ~act_q;
          aim_d   = AIM_LD;
        end else if (bus.frame_tick) begin
          wd_d = wd_q + T_ONE;
        end
      end
      state_q[3]: begin
        if (bus.Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.launch        = launch_q;
  assign bus.active_player = act_q;
  assign bus.p1_score      = p1_q;
  assign bus.p2_score      = p2_q;
  assign bus.aim_time      = aim_q;
  assign bus.winner        = win_q;
  assign bus.q_Idle        = state_q[0];
  assign bus.q_Aim         = state_q[1];
  assign bus.q_Flight      = state_q[2];
  assign bus.q_GameOver    = state_q[3];

endmodule

// File: tb/tb_wwm_turn_ctrl.sv
// Directed bench for wwm_turn_ctrl: default instance plus a short-timer
// instance (AIM_FRAMES=3, FLIGHT_FRAMES=4) for timeout/watchdog cases.
module tb_wwm_turn_ctrl;

  logic clk;
  logic Reset;
  int   n_chk;
  int   n_fail;
  logic [25:0] obs;
  logic [25:0] expv;

  localparam logic [6:0] ST = 7'b1000000;
  localparam logic [6:0] AK = 7'b0100000;
  localparam logic [6:0] F1 = 7'b0010000;
  localparam logic [6:0] F2 = 7'b0001000;
  localparam logic [6:0] TK = 7'b0000100;
  localparam logic [6:0] HT = 7'b0000010;
  localparam logic [6:0] MS = 7'b0000001;
  localparam logic [6:0] NO = 7'b0000000;

  localparam logic [3:0] I = 4'b1000;
  localparam logic [3:0] A = 4'b0100;
  localparam logic [3:0] F = 4'b0010;
  localparam logic [3:0] G = 4'b0001;

  wwm_turn_if #(.SCORE_W(4), .TIMER_W(10)) ia ();
  wwm_turn_if #(.SCORE_W(4), .TIMER_W(10)) ib ();

  wwm_turn_ctrl dut_a (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ia.slave)
  );

  wwm_turn_ctrl #(
    .WIN_SCORE     (3),
    .SCORE_W       (4),
    .AIM_FRAMES    (3),
    .FLIGHT_FRAMES (4),
    .TIMER_W       (10)
  ) dut_b (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] mk(
    input logic [3:0] st, input logic l, input logic a,
    input logic [1:0] w, input logic [3:0] s1,
    input logic [3:0] s2, input logic [9:0] t);
    return {st, l, a, w, s1, s2, t};
  endfunction

  function automatic logic [25:0] snap_a();
    return {ia.q_Idle, ia.q_Aim, ia.q_Flight, ia.q_GameOver,
            ia.launch, ia.active_player, ia.winner,
            ia.p1_score, ia.p2_score, ia.aim_time};
  endfunction

  function automatic logic [25:0] snap_b();
    return {ib.q_Idle, ib.q_Aim, ib.q_Flight, ib.q_GameOver,
            ib.launch, ib.active_player, ib.winner,
            ib.p1_score, ib.p2_score, ib.aim_time};
  endfunction

  task automatic drv_a(input logic [6:0] v);
    {ia.Start, ia.Ack, ia.p1_fire, ia.p2_fire,
     ia.frame_tick, ia.flight_hit, ia.flight_miss} = v;
    @(negedge clk);
    {ia.Start, ia.Ack, ia.p1_fire, ia.p2_fire,
     ia.frame_tick, ia.flight_hit, ia.flight_miss} = 7'b0;
  endtask

  task automatic drv_b(input logic [6:0] v);
    {ib.Start, ib.Ack, ib.p1_fire, ib.p2_fire,
     ib.frame_tick, ib.flight_hit, ib.flight_miss} = v;
    @(negedge clk);
    {ib.Start, ib.Ack, ib.p1_fire, ib.p2_fire,
     ib.frame_tick, ib.flight_hit, ib.flight_miss} = 7'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    obs = snap_a(); expv = mk(I, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_a: got %h want %h", obs, expv);
    end
    obs = snap_b();
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_b: got %h want %h", obs, expv);
    end
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    drv_a(ST);
    obs = snap_a(); expv = mk(A, 0, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL start: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_fire();
    drv_a(F2);
    obs = snap_a(); expv = mk(A, 0, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL wrong_fire: got %h want %h", obs, expv);
    end
    drv_a(F1);
    obs = snap_a(); expv = mk(F, 1, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL launch: got %h want %h", obs, expv);
    end
    drv_a(NO);
    obs = snap_a(); expv = mk(F, 0, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL launch_1cyc: got %h want %h", obs, expv);
    end
    drv_a(MS);
    obs = snap_a(); expv = mk(A, 0, 1, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL miss: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_hit_miss();
    drv_a(HT);
    obs = snap_a(); expv = mk(A, 0, 1, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL hit_in_aim: got %h want %h", obs, expv);
    end
    drv_a(F2);
    drv_a(MS);
    obs = snap_a(); expv = mk(A, 0, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL p2_miss: got %h want %h", obs, expv);
    end
    drv_a(F1);
    drv_a(HT | MS);
    obs = snap_a(); expv = mk(A, 0, 1, 2'b00, 1, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL hit_and_miss: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_game();
    drv_a(F2);
    drv_a(MS);
    drv_a(F1);
    drv_a(HT);
    obs = snap_a(); expv = mk(A, 0, 1, 2'b00, 2, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL hit2: got %h want %h", obs, expv);
    end
    drv_a(F2);
    drv_a(MS);
    drv_a(F1);
    drv_a(HT);
    obs = snap_a(); expv = mk(G, 0, 0, 2'b01, 3, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL game_over: got %h want %h", obs, expv);
    end
    drv_a(ST);
    n_chk++;
    if (snap_a() !== expv) begin
      n_fail++;
      $display("FAIL start_in_over: got %h want %h", snap_a(), expv);
    end
    drv_a(AK);
    obs = snap_a(); expv = mk(I, 0, 0, 2'b01, 3, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL ack_idle: got %h want %h", obs, expv);
    end
    drv_a(ST);
    obs = snap_a(); expv = mk(A, 0, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL restart: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_aim_timeout();
    drv_b(ST);
    drv_b(TK);
    obs = snap_b(); expv = mk(A, 0, 0, 2'b00, 0, 0, 2);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL aim_dec: got %h want %h", obs, expv);
    end
    drv_b(TK);
    drv_b(TK);
    obs = snap_b(); expv = mk(A, 0, 1, 2'b00, 0, 0, 3);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL forfeit_p1: got %h want %h", obs, expv);
    end
    for (int k = 0; k < 3; k++) drv_b(TK);
    obs = snap_b(); expv = mk(A, 0, 0, 2'b00, 0, 0, 3);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL forfeit_p2: got %h want %h", obs, expv);
    end
    drv_b(TK);
    drv_b(TK);
    drv_b(TK | F1);
    obs = snap_b(); expv = mk(F, 1, 0, 2'b00, 0, 0, 1);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL fire_wins: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_watchdog();
    for (int k = 0; k < 3; k++) drv_b(TK);
    obs = snap_b(); expv = mk(F, 0, 0, 2'b00, 0, 0, 1);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL wd_hold: got %h want %h", obs, expv);
    end
    drv_b(TK);
    obs = snap_b(); expv = mk(A, 0, 1, 2'b00, 0, 0, 3);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL wd_expire: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_reset_flight();
    drv_a(F1);
    obs = snap_a(); expv = mk(F, 1, 0, 2'b00, 0, 0, 600);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want %h", obs, expv);
    end
    Reset = 1'b1;
    #1;
    obs = snap_a(); expv = mk(I, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs, expv);
    end
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Reset  = 1'b0;
    {ia.Start, ia.Ack, ia.p1_fire, ia.p2_fire,
     ia.frame_tick, ia.flight_hit, ia.flight_miss} = 7'b0;
    {ib.Start, ib.Ack, ib.p1_fire, ib.p2_fire,
     ib.frame_tick, ib.flight_hit, ib.flight_miss} = 7'b0;
    test_reset();
    test_start();
    test_fire();
    test_hit_miss();
    test_game();
    test_aim_timeout();
    test_watchdog();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wwm_turn_ctrl.md
Name: wwm_turn_ctrl

Overview:
Two-player turn scheduler for World War Math. It grants the single shared projectile/animation engine to Player 1 or Player 2 in alternation and issues the launch pulse. It consumes hit/miss results from the flight logic, keeps both scores and a per-turn aim timer, and declares the game winner. It sits between the player input logic (debounced fire pulses) and the projectile animation/collision datapath.

Parameters:
WIN_SCORE, 3, hits needed to win (1..2^SCORE_W-1)
SCORE_W, 4, score counter width
AIM_FRAMES, 600, frame ticks allowed per aim phase (10 s at 60 Hz)
FLIGHT_FRAMES, 255, watchdog: maximum frame ticks per flight before a forced miss
TIMER_W, 10, aim/flight timer width

Ports:
clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  level; begins a game from IDLE
Ack  input  1  level; returns from GAME_OVER to IDLE
p1_fire  input  1  one-cycle fire pulse, Player 1
p2_fire  input  1  one-cycle fire pulse, Player 2
frame_tick  input  1  one-cycle pulse per video frame
flight_hit  input  1  one-cycle pulse: projectile hit opponent target
flight_miss  input  1  one-cycle pulse: projectile left play area
launch  output  1  one-cycle pulse: load and start projectile for active_player
active_player  output  1  0 = Player 1, 1 = Player 2
p1_score  output  SCORE_W  Player 1 hits
p2_score  output  SCORE_W  Player 2 hits
aim_time  output  TIMER_W  remaining aim ticks (for HUD)
winner  output  2  00 none, 01 P1, 10 P2
q_Idle, q_Aim, q_Flight, q_GameOver  output  1 each  one-hot state flags

Behaviour:
- Reset (any time, incl. mid-flight): state IDLE; launch 0, active_player 0, scores 0, aim_time 0, winner 00, flight watchdog 0. q_Idle=1, others 0.
- All outputs are registered; state flags decode directly from the one-hot state register.
- IDLE: Start -> AIM; scores cleared, winner 00, active_player 0, aim_time loaded with AIM_FRAMES. Fire, hit and miss inputs are ignored.
- AIM: only the active player's fire is accepted; the other player's fire is ignored.
- On an accepted fire: next cycle state FLIGHT and launch=1 for exactly that one cycle; flight watchdog cleared.
- Each frame_tick in AIM decrements aim_time (no underflow).
- If a tick arrives with aim_time==1 and no accepted fire that cycle: turn is forfeited. active_player toggles, aim_time reloads AIM_FRAMES, state stays AIM, no launch.
- Accepted fire and expiring tick in the same cycle: fire wins.
- FLIGHT: aim_time holds. frame_tick increments the watchdog.
- flight_hit: active player's score +1, saturating at 2^SCORE_W-1.
  - If the new score == WIN_SCORE: GAME_OVER, winner set to 01 or 10.
  - Otherwise: toggle active_player, reload aim_time, go to AIM.
- flight_miss, or watchdog reaching FLIGHT_FRAMES: toggle active_player, reload aim_time, go to AIM; no score change.
- hit and miss in the same cycle: hit wins. hit and watchdog expiry in the same cycle: hit wins.
- hit/miss pulses outside FLIGHT are ignored.
- GAME_OVER: scores, winner and active_player hold. Ack -> IDLE; scores and winner persist in IDLE until the next Start. Start is ignored outside IDLE.
- Transition latency: every state transition takes effect on the clock edge sampling the causing input (1 cycle).

Test Plan:
- Reset, Start=1 one cycle -> q_Aim=1, active_player=0, aim_time=600, scores 0/0, winner 00.
- In AIM (P1), p2_fire pulse -> no change. p1_fire pulse -> next cycle q_Flight=1, launch=1 for exactly 1 cycle. Then flight_miss -> q_Aim=1, active_player=1, p1_score=0.
- P1 flight, then flight_hit and flight_miss in the same cycle -> p1_score=1, active_player=1, state AIM.
- AIM_FRAMES=3: 3 frame_ticks with no fire -> active_player toggles, aim_time=3, no launch. Repeat with p1_fire on the 3rd tick -> launch asserts, no forfeit.
- Alternate P1 hit / P2 miss three times -> after the 3rd P1 hit q_GameOver=1, winner=01, p1_score=3. Ack -> q_Idle=1 with score held. Start -> scores 0.
- Assert Reset mid-FLIGHT -> immediately IDLE, launch 0, scores 0. FLIGHT_FRAMES=4 with no hit/miss -> forced miss on the 4th tick.
